// File: rtl/sincronizador_antirrebote_if.sv
// Bundle of the conditioned-input signals between a raw button/switch source
// and the debouncer; the master drives the raw level, the slave returns status.
interface sincronizador_antirrebote_if;
  logic       senal_entrada;
  logic       senal_limpia;
  logic       ocupado;
  logic [7:0] rebotes;

  modport master (
    output senal_entrada,
    input  senal_limpia,
    input  ocupado,
    input  rebotes
  );

  modport slave (
    input  senal_entrada,
    output senal_limpia,
    output ocupado,
    output rebotes
  );
endinterface

// File: rtl/sincronizador_antirrebote.sv
// Synchronises a raw asynchronous input and debounces it: a new level is accepted
// only after DEBOUNCE_CYCLES consecutive identical synchronised samples.
module sincronizador_antirrebote #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                        clk,
  input  logic                        rst,
  sincronizador_antirrebote_if.slave  bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    ESTABLE_BAJO,
    VALIDANDO_ALTO,
    ESTABLE_ALTO,
    VALIDANDO_BAJO
  } estado_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  estado_t                estado_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   limpia_q;
  logic                   ocupado_q;
  logic [7:0]             rebotes_q;
  logic [7:0]             rebotes_d;
  logic                   ultimo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.senal_entrada};
    end
  end

  assign sync      = sync_q[SYNC_STAGES-1];
  assign ultimo    = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign rebotes_d = (rebotes_q == 8'hFF) ? rebotes_q : rebotes_q + 8'd1;

  // An aborted validation returns to the old stable state without touching the output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q  <= ESTABLE_BAJO;
      cnt_q     <= '0;
      limpia_q  <= 1'b0;
      ocupado_q <= 1'b0;
      rebotes_q <= 8'd0;
    end else begin
      case (estado_q)
        ESTABLE_BAJO: begin
          if (sync) begin
            estado_q  <= VALIDANDO_ALTO;
            cnt_q     <= CNT_W'(1);
            ocupado_q <= 1'b1;
          end else begin
            cnt_q <= '0;
          end
        end
        VALIDANDO_ALTO: begin
          if (!sync) begin
            estado_q  <= ESTABLE_BAJO;
            cnt_q     <= '0;
            ocupado_q <= 1'b0;
            rebotes_q <= rebotes_d;
          end else if (ultimo) begin
            estado_q  <= ESTABLE_ALTO;
            cnt_q     <= '0;
            ocupado_q <= 1'b0;
            limpia_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ESTABLE_ALTO: begin
          if (!sync) begin
            estado_q  <= VALIDANDO_BAJO;
            cnt_q     <= CNT_W'(1);
            ocupado_q <= 1'b1;
          end else begin
            cnt_q <= '0;
          end
        end
        VALIDANDO_BAJO: begin
          if (sync) begin
            estado_q  <= ESTABLE_ALTO;
            cnt_q     <= '0;
            ocupado_q <= 1'b0;
            rebotes_q <= rebotes_d;
          end else if (ultimo) begin
            estado_q  <= ESTABLE_BAJO;
            cnt_q     <= '0;
            ocupado_q <= 1'b0;
            limpia_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          estado_q  <= ESTABLE_BAJO;
          cnt_q     <= '0;
          ocupado_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.senal_limpia = limpia_q;
  assign bus.ocupado      = ocupado_q;
  assign bus.rebotes      = rebotes_q;

endmodule

// File: tb/tb_sincronizador_antirrebote.sv
// Randomised and directed bench for the debouncer: a per-cycle scoreboard fed by a
// run-length reference model, plus latency, saturation and reset checks.
module tb_sincronizador_antirrebote;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;

  typedef struct packed {
    logic       limpia;
    logic       ocupado;
    logic [7:0] reb;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #50 clk = ~clk;

  sincronizador_antirrebote_if bus ();

  sincronizador_antirrebote #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   rises = 0;
  int   ncyc  = 0;
  logic prev_limpia = 1'b0;

  // Reference model: input delayed through the synchroniser, then a run of
  // DEBOUNCE_CYCLES samples differing from the held level flips it.
  bit   pipe[$];
  bit   m_level;
  int   m_streak;
  int   m_reb;
  bit   in_now;

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < SYNC_STAGES; i++) pipe.push_back(1'b0);
    m_level  = 1'b0;
    m_streak = 0;
    m_reb    = 0;
  endtask

  task automatic model_edge(bit in_v);
    bit   s;
    exp_t e;
    pipe.push_back(in_v);
    s = pipe.pop_front();
    if (s != m_level) begin
      m_streak++;
      if (m_streak == DEBOUNCE_CYCLES) begin
        m_level  = s;
        m_streak = 0;
      end
    end else begin
      if (m_streak > 0 && m_reb < 255) m_reb++;
      m_streak = 0;
    end
    e.limpia  = m_level;
    e.ocupado = (m_streak > 0);
    e.reb     = 8'(m_reb);
    exp_q.push_back(e);
  endtask

  task automatic check(string name, int got, int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end else begin
      $display("[TB] %s ok: %0d", name, got);
    end
  endtask

  // Monitor: one scoreboard pop per clock edge once expectations exist.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(posedge clk);
      #1;
      ncyc++;
      if (bus.senal_limpia === 1'b1 && prev_limpia === 1'b0) rises++;
      prev_limpia = bus.senal_limpia;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {bus.senal_limpia, bus.ocupado, bus.rebotes};
        tests++;
        if (got !== e) begin
          fails++;
          $display("FAIL scoreboard cyc %0d: got limpia=%b ocupado=%b rebotes=%0d, want limpia=%b ocupado=%b rebotes=%0d",
                   ncyc, got.limpia, got.ocupado, got.reb, e.limpia, e.ocupado, e.reb);
        end else begin
          $display("[TB] cyc %0d in=%b limpia=%b ocupado=%b rebotes=%0d", ncyc, in_now,
                   got.limpia, got.ocupado, got.reb);
        end
      end
    end
  end

  task automatic cycle(bit v);
    @(negedge clk);
    bus.senal_entrada = v;
    in_now = v;
    if (rst === 1'b1) model_edge(v);
    else exp_q.push_back('0);
  endtask

  task automatic do_reset(int n, bit v);
    @(negedge clk);
    rst = 1'b0;
    bus.senal_entrada = v;
    in_now = v;
    model_reset();
    #1;
    check("reset_async_outputs", int'({bus.senal_limpia, bus.ocupado, bus.rebotes}), 0);
    exp_q.push_back('0);
    repeat (n - 1) cycle(v);
  endtask

  task automatic release_rst(bit v);
    @(negedge clk);
    rst = 1'b1;
    bus.senal_entrada = v;
    in_now = v;
    model_edge(v);
  endtask

  // Edge index (0 = first edge after the change) at which senal_limpia reaches v.
  task automatic measure(bit v, bit rel, int budget, output int lat, output int busy);
    lat  = -1;
    busy = 0;
    for (int k = 0; k < budget; k++) begin
      if (k == 0 && rel) release_rst(v);
      else cycle(v);
      @(posedge clk);
      #2;
      if (lat < 0 && bus.ocupado === 1'b1) busy++;
      if (lat < 0 && bus.senal_limpia === v) lat = k;
    end
  endtask

  initial begin
    int lat, busy, r0, hold;
    bit v;
    rst = 1'b0;
    bus.senal_entrada = 1'b0;
    in_now = 1'b0;
    model_reset();

    // Reset then clean rise
    do_reset(2, 1'b0);
    release_rst(1'b0);
    repeat (3) cycle(1'b0);
    measure(1'b1, 1'b0, 10, lat, busy);
    check("rise_latency", lat, SYNC_STAGES + DEBOUNCE_CYCLES - 1);
    check("rise_ocupado_cycles", busy, DEBOUNCE_CYCLES - 1);
    check("rise_rebotes", int'(bus.rebotes), 0);

    // Clean fall
    r0 = rises;
    measure(1'b0, 1'b0, 10, lat, busy);
    check("fall_latency", lat, SYNC_STAGES + DEBOUNCE_CYCLES - 1);
    check("fall_no_rising_edge", rises - r0, 0);

    // Bounce burst
    r0 = rises;
    cycle(1'b1); cycle(1'b1); cycle(1'b0);
    cycle(1'b1); cycle(1'b1); cycle(1'b1); cycle(1'b0);
    repeat (10) cycle(1'b1);
    @(posedge clk);
    #2;
    check("burst_single_rise", rises - r0, 1);
    check("burst_rebotes", int'(bus.rebotes), 2);
    check("burst_limpia", int'(bus.senal_limpia), 1);

    // Reset mid-validation
    repeat (10) cycle(1'b0);
    repeat (4) cycle(1'b1);
    @(posedge clk);
    #2;
    check("midval_ocupado", int'(bus.ocupado), 1);
    do_reset(2, 1'b1);
    measure(1'b1, 1'b1, 10, lat, busy);
    check("midval_relatency", lat, SYNC_STAGES + DEBOUNCE_CYCLES - 1);

    // Input high at reset release
    do_reset(3, 1'b1);
    measure(1'b1, 1'b1, 8, lat, busy);
    check("high_at_release_latency", lat, SYNC_STAGES + DEBOUNCE_CYCLES - 1);

    // Saturation
    do_reset(2, 1'b0);
    release_rst(1'b0);
    repeat (3) cycle(1'b0);
    r0 = rises;
    for (int p = 0; p < 300; p++) begin
      cycle(1'b1);
      cycle(1'b0);
    end
    repeat (4) cycle(1'b0);
    @(posedge clk);
    #2;
    check("sat_rebotes", int'(bus.rebotes), 255);
    check("sat_no_rise", rises - r0, 0);

    // Random segments with occasional resets
    do_reset(2, 1'b0);
    release_rst(1'b0);
    for (int sgm = 0; sgm < 60; sgm++) begin
      if ($urandom_range(0, 19) == 0) begin
        v = 1'($urandom_range(0, 1));
        do_reset(int'($urandom_range(1, 3)), v);
        release_rst(v);
      end
      v    = 1'($urandom_range(0, 1));
      hold = int'($urandom_range(1, 6));
      repeat (hold) cycle(v);
    end
    repeat (3) cycle(in_now);

    @(posedge clk);
    #3;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sincronizador_antirrebote.md
Name: sincronizador_antirrebote

Overview:
- Conditions a raw asynchronous pushbutton/switch input into a clean, glitch-free level for the downstream `detector_flanco` stage.
- Processing chain: multi-flop synchroniser → debounce FSM with a stability counter.
- Output `senal_limpia` feeds `detector_flanco.senal_entrada` directly.
- Also reports whether a validation is in progress and counts rejected bounces for lab diagnostics.
- Runs in the 10 MHz system clock domain.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flip-flops; legal range 2..4.
- DEBOUNCE_CYCLES, 100000: consecutive identical synchronised samples needed to accept a new level (10 ms at 10 MHz); must be ≥ 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): width of the stability counter; derived, not overridden.

Ports:
- clk  input  1  system clock, 10 MHz, rising-edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted); deassertion assumed synchronous to clk upstream.
- senal_entrada  input  1  raw asynchronous input (button/switch), may bounce.
- senal_limpia  output  1  debounced, synchronised level; feeds detector_flanco.
- ocupado  output  1  high while a level change is being validated.
- rebotes  output  8  saturating count of aborted validations since reset.

Behaviour:
- Reset (rst=0, asynchronous):
  - all synchroniser flops 0; state ESTABLE_BAJO; counter 0.
  - senal_limpia=0, ocupado=0, rebotes=0.
  - Takes effect immediately, including mid-validation; any partial count is discarded.
- Synchroniser: shift register of SYNC_STAGES flops; sync = last stage. Only sync is used by the FSM.
- FSM states: ESTABLE_BAJO, VALIDANDO_ALTO, ESTABLE_ALTO, VALIDANDO_BAJO.
- ESTABLE_BAJO:
  - sync=1 → VALIDANDO_ALTO, counter ← 1.
  - else hold; counter 0.
- VALIDANDO_ALTO:
  - sync=1 and counter = DEBOUNCE_CYCLES−1 → ESTABLE_ALTO, senal_limpia ← 1, counter ← 0.
  - sync=1 otherwise → counter ← counter+1.
  - sync=0 → ESTABLE_BAJO, counter ← 0, rebotes ← rebotes+1 (saturates at 255).
- ESTABLE_ALTO / VALIDANDO_BAJO: mirror of the above with polarity inverted; acceptance drives senal_limpia ← 0.
- senal_limpia is registered and changes only on the acceptance edge; it never toggles as a result of an aborted validation.
- ocupado = 1 exactly when the state is VALIDANDO_ALTO or VALIDANDO_BAJO (registered state decode, no combinational path from senal_entrada).
- Latency: if senal_entrada changes and stays stable before clock edge 0, senal_limpia changes on edge SYNC_STAGES+DEBOUNCE_CYCLES−1.
  - Example: SYNC_STAGES=2, DEBOUNCE_CYCLES=4 → edge 5.
- Pulses shorter than one clock period may or may not be captured by the synchroniser; both outcomes are legal. If captured, a pulse is treated as a bounce.
- Input already high when reset is released: output stays 0 until full validation completes (no bypass).
- rebotes increments only on an abort, never on acceptance; it holds at 255 once saturated.
- Counter never exceeds DEBOUNCE_CYCLES−1; no wrap-around is possible.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, SYNC_STAGES=2; 100 ns clock):
- Reset then clean rise:
  - Stimulus: rst low for 2 cycles, release; senal_entrada 0→1 held 10 cycles.
  - Required: senal_limpia rises on the 5th edge after the change; ocupado high for 3 cycles beforehand; rebotes=0.
- Clean fall:
  - Stimulus: from a stable 1, drop senal_entrada to 0 and hold.
  - Required: senal_limpia falls on edge 5; a downstream detector_flanco sees no positive edge.
- Bounce burst:
  - Stimulus: 1 (2 cycles), 0 (1), 1 (3), 0 (1), then 1 held.
  - Required: senal_limpia rises only after 4 consecutive synchronised 1s; exactly one rising transition; rebotes=2.
- Reset mid-validation:
  - Stimulus: assert rst while ocupado=1 (counter=2).
  - Required: in the same cycle, senal_limpia=0, ocupado=0, rebotes=0; after release with input held 1, a full 5-edge latency applies again.
- Saturation:
  - Stimulus: 300 single-cycle 1-pulses separated by 0s.
  - Required: rebotes stops at 255; senal_limpia stays 0 throughout.
- Input high at reset release:
  - Stimulus: senal_entrada=1 before rst deasserts.
  - Required: senal_limpia=0 until edge 5 after release, then 1.
